ila_capture_engine: RTL and testbench
=====================================

# ila_capture_engine

Parametrised integrated logic analyser capture engine. It records DATA_WIDTH-bit samples into a circular buffer of 2^ADDR_WIDTH entries. It triggers on an external strobe, a masked pattern match, or a rising edge of that match, then captures a programmable number of post-trigger samples. The frozen buffer is read out oldest-first through a request/valid handshake. It replaces the fixed-mode ILA in the debug datapath and sits between the probed bus and the register/readout interface.

## Interface
- DATA_WIDTH, 64, sample and readout width
- ADDR_WIDTH, 8, buffer depth DEPTH = 2^ADDR_WIDTH
- COUNT_WIDTH, 16, width of post-trigger count
- clock  in  1  sole clock; all logic rising-edge
- reset  in  1  asynchronous, active-high; returns engine to IDLE
- arm_i  in  1  single-cycle pulse; starts (or restarts) a capture
- ext_trigger_i  in  1  external trigger strobe
- trig_mode_i  in  2  00 external, 01 pattern, 10 pattern OR external, 11 pattern rising edge
- trig_value_i  in  DATA_WIDTH  pattern value
- trig_mask_i  in  DATA_WIDTH  1 = bit compared
- post_count_i  in  COUNT_WIDTH  samples written after the trigger sample
- data_in  in  DATA_WIDTH  probed sample
- rd_req_i  in  1  readout request, one word per accepted cycle
- data_out  out  DATA_WIDTH  readout word
- rd_valid_o  out  1  data_out valid
- rd_last_o  out  1  with rd_valid_o, final (DEPTH-th) word
- primed_o  out  1  buffer holds DEPTH pre-trigger samples
- triggered_o  out  1  trigger accepted this capture
- done_o  out  1  capture frozen, readout permitted
- trig_addr_o  out  ADDR_WIDTH  buffer address of trigger sample

## Operation
- States: IDLE, FILL, ARMED, POST, DONE.
- match = ((data_in XOR trig_value_i) AND trig_mask_i) == 0. match_prev is a register updated every cycle in FILL, ARMED and POST, and cleared on arm.
- trig_hit by mode:
  - 00: ext_trigger_i
  - 01: match
  - 10: match OR ext_trigger_i
  - 11: match AND NOT match_prev
- Mode, value and mask are sampled live. post_count_i is latched on arm and clamped to DEPTH-1.
- IDLE: no writes. arm -> FILL, with waddr=0, fill counter=0, triggered_o/done_o/primed_o cleared.
- FILL: data_in is written at waddr each cycle, and waddr increments (wraps mod DEPTH). trig_hit is ignored. After DEPTH writes, primed_o=1 and the state moves to ARMED.
- ARMED: circular writes continue.
  - On trig_hit, the current sample is written, trig_addr_o takes that address, and triggered_o=1.
  - If the latched count is 0, the state moves to DONE; otherwise it moves to POST.
- POST: circular writes continue. A down-counter decrements per write, and the last post sample moves the state to DONE.
- DONE: no writes.
  - raddr starts at waddr (the oldest sample). Each rd_req_i cycle reads raddr and increments it.
  - The DEPTH-th accepted request produces rd_last_o. After that word, done_o clears and the state moves to IDLE. triggered_o, primed_o and trig_addr_o hold until the next arm.
  - rd_req_i outside DONE, or after the last request has been accepted, is ignored.
- arm_i in any state aborts and restarts as from IDLE, and has priority over trig_hit and rd_req_i.
- All counters and pointers wrap modulo their width. There are no overflow flags.

## Timing
- Reset (async assert) clears all outputs to 0 and sets state=IDLE, waddr=raddr=0 and match_prev=0. Reset deassertion is synchronous to clock.
- The first write occurs on the edge after the arm edge.
- The trigger is combinational on the same-cycle data_in, so the trigger sample is the one written on the trigger edge. There is no input delay.
- primed_o rises on the edge completing the DEPTH-th FILL write.
- Completing post-trigger samples:
  - done_o rises on the edge completing the final write.
  - The earliest rd_req_i that is accepted is the cycle after done_o rises.
- Read latency is 1: a request accepted at edge N gives data_out/rd_valid_o at edge N+1. rd_valid_o is a one-cycle pulse per request.
  - Back-to-back requests stream one word per cycle.
  - data_out holds its last value when not valid.
- Reset mid-operation discards the capture immediately. Memory contents are don't-care.

## Test plan
DATA_WIDTH=8, ADDR_WIDTH=4 (DEPTH 16), data_in = free-running counter.
- Mode 00, post=3, arm while data=0, ext_trigger_i when data=40 -> done_o 3 cycles later; continuous rd_req_i reads 28..43 in 16 consecutive cycles, rd_last_o on 43, trig_addr_o points at 40.
- Mode 00, ext_trigger_i at data 5 (FILL) and 20 -> first ignored, primed_o high after 16 writes, trigger at 20; readout 17..32 with post=12.
- Mode 01, value 0x3C, mask 0xF0, post=0 -> trigger at 0x30; done_o immediately; readout 0x21..0x30, rd_last_o with 0x30.
- Mode 11, data_in held at matching 0x55 from arm -> no trigger; drive 0x00 then 0x55 -> single trigger on the 0x55 following 0x00.
- post_count_i=20 -> clamped to 15; the trigger sample is the first word read; rd_last_o on the 16th word.
- Reset asserted mid-POST -> all outputs 0 at once. A separate check: arm after only 5 of 16 reads in DONE -> rd_valid_o stops, done_o/primed_o/triggered_o clear, and a new FILL begins.

Source files
------------

// File: rtl/ila_capture_engine_if.sv
// Bundles the capture-engine control, probe and readout signals.
// The engine connects through the slave modport; the controller/probe side uses master.
interface ila_capture_engine_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
);
    logic                   arm_i;
    logic                   ext_trigger_i;
    logic [1:0]             trig_mode_i;
    logic [DATA_WIDTH-1:0]  trig_value_i;
    logic [DATA_WIDTH-1:0]  trig_mask_i;
    logic [COUNT_WIDTH-1:0] post_count_i;
    logic [DATA_WIDTH-1:0]  data_in;
    logic                   rd_req_i;
    logic [DATA_WIDTH-1:0]  data_out;
    logic                   rd_valid_o;
    logic                   rd_last_o;
    logic                   primed_o;
    logic                   triggered_o;
    logic                   done_o;
    logic [ADDR_WIDTH-1:0]  trig_addr_o;

    modport master (
        output arm_i, ext_trigger_i, trig_mode_i, trig_value_i, trig_mask_i,
               post_count_i, data_in, rd_req_i,
        input  data_out, rd_valid_o, rd_last_o, primed_o, triggered_o,
               done_o, trig_addr_o
    );

    modport slave (
        input  arm_i, ext_trigger_i, trig_mode_i, trig_value_i, trig_mask_i,
               post_count_i, data_in, rd_req_i,
        output data_out, rd_valid_o, rd_last_o, primed_o, triggered_o,
               done_o, trig_addr_o
    );
endinterface

// File: rtl/ila_capture_engine.sv
// Logic-analyser capture engine: circular sample buffer, pattern/external trigger,
// programmable post-trigger depth and oldest-first readout of the frozen buffer.
module ila_capture_engine #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ila_capture_engine_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FILL  = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_POST  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0]  ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_MAX   = {ADDR_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] POST_MAX   = COUNT_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0]  mem_r [DEPTH];
    logic [2:0]             state_r;
    logic [ADDR_WIDTH-1:0]  waddr_r;
    logic [ADDR_WIDTH-1:0]  raddr_r;
    logic [ADDR_WIDTH-1:0]  fill_cnt_r;
    logic [ADDR_WIDTH-1:0]  rd_cnt_r;
    logic [COUNT_WIDTH-1:0] post_len_r;
    logic [COUNT_WIDTH-1:0] post_cnt_r;
    logic                   match_prev_r;
    logic [DATA_WIDTH-1:0]  data_out_r;
    logic                   rd_valid_r;
    logic                   rd_last_r;
    logic                   primed_r;
    logic                   triggered_r;
    logic                   done_r;
    logic [ADDR_WIDTH-1:0]  trig_addr_r;

    logic                   match_s;
    logic                   trig_hit_s;
    logic                   wr_en_s;
    logic [COUNT_WIDTH-1:0] post_clamped_s;

    // Trigger decode on the live sample; arm always wins over writes.
    always_comb begin
        trig_hit_s     = 1'b0;
        match_s        = (((bus.data_in ^ bus.trig_value_i) & bus.trig_mask_i) == {DATA_WIDTH{1'b0}});
        wr_en_s        = ((state_r == ST_FILL) || (state_r == ST_ARMED) || (state_r == ST_POST)) && !bus.arm_i;
        post_clamped_s = (bus.post_count_i > POST_MAX) ? POST_MAX : bus.post_count_i;
        case (bus.trig_mode_i)
            2'b00:   trig_hit_s = bus.ext_trigger_i;
            2'b01:   trig_hit_s = match_s;
            2'b10:   trig_hit_s = match_s | bus.ext_trigger_i;
            2'b11:   trig_hit_s = match_s & ~match_prev_r;
            default: trig_hit_s = 1'b0;
        endcase
    end

    // Sample buffer; contents are don't-care after reset so it carries none.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[waddr_r] <= bus.data_in;
        end
    end

    // Capture state machine, pointers, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            waddr_r      <= ADDR_ZERO;
            raddr_r      <= ADDR_ZERO;
            fill_cnt_r   <= ADDR_ZERO;
            rd_cnt_r     <= ADDR_ZERO;
            post_len_r   <= COUNT_ZERO;
            post_cnt_r   <= COUNT_ZERO;
            match_prev_r <= 1'b0;
            data_out_r   <= {DATA_WIDTH{1'b0}};
            rd_valid_r   <= 1'b0;
            rd_last_r    <= 1'b0;
            primed_r     <= 1'b0;
            triggered_r  <= 1'b0;
            done_r       <= 1'b0;
            trig_addr_r  <= ADDR_ZERO;
        end else if (bus.arm_i) begin
            state_r      <= ST_FILL;
            waddr_r      <= ADDR_ZERO;
            raddr_r      <= ADDR_ZERO;
            fill_cnt_r   <= ADDR_ZERO;
            rd_cnt_r     <= ADDR_ZERO;
            post_len_r   <= post_clamped_s;
            match_prev_r <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_last_r    <= 1'b0;
            primed_r     <= 1'b0;
            triggered_r  <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_FILL: begin
                    waddr_r      <= waddr_r + ADDR_ONE;
                    fill_cnt_r   <= fill_cnt_r + ADDR_ONE;
                    match_prev_r <= match_s;
                    if (fill_cnt_r == ADDR_MAX) begin
                        primed_r <= 1'b1;
                        state_r  <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    waddr_r      <= waddr_r + ADDR_ONE;
                    match_prev_r <= match_s;
                    if (trig_hit_s) begin
                        trig_addr_r <= waddr_r;
                        triggered_r <= 1'b1;
                        post_cnt_r  <= post_len_r;
                        if (post_len_r == COUNT_ZERO) begin
                            state_r  <= ST_DONE;
                            done_r   <= 1'b1;
                            raddr_r  <= waddr_r + ADDR_ONE;
                            rd_cnt_r <= ADDR_ZERO;
                        end else begin
                            state_r <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    waddr_r      <= waddr_r + ADDR_ONE;
                    match_prev_r <= match_s;
                    post_cnt_r   <= post_cnt_r - COUNT_ONE;
                    if (post_cnt_r == COUNT_ONE) begin
                        state_r  <= ST_DONE;
                        done_r   <= 1'b1;
                        raddr_r  <= waddr_r + ADDR_ONE;
                        rd_cnt_r <= ADDR_ZERO;
                    end
                end
                ST_DONE: begin
                    // raddr starts one past the final write, i.e. at the oldest sample.
                    if (bus.rd_req_i) begin
                        data_out_r <= mem_r[raddr_r];
                        rd_valid_r <= 1'b1;
                        raddr_r    <= raddr_r + ADDR_ONE;
                        rd_cnt_r   <= rd_cnt_r + ADDR_ONE;
                        if (rd_cnt_r == ADDR_MAX) begin
                            rd_last_r <= 1'b1;
                            done_r    <= 1'b0;
                            state_r   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out    = data_out_r;
    assign bus.rd_valid_o  = rd_valid_r;
    assign bus.rd_last_o   = rd_last_r;
    assign bus.primed_o    = primed_r;
    assign bus.triggered_o = triggered_r;
    assign bus.done_o      = done_r;
    assign bus.trig_addr_o = trig_addr_r;
endmodule

// File: tb/tb_ila_capture_engine.sv
// Directed bench for ila_capture_engine at DATA_WIDTH=8, DEPTH=16 with a counter probe.
module tb_ila_capture_engine;
    logic clk;
    logic rst;
    logic free_run;
    int   vectors;
    int   miscompares;

    ila_capture_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .COUNT_WIDTH(16)) bus ();

    ila_capture_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .COUNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (free_run) bus.data_in = bus.data_in + 8'd1;
    endtask

    task automatic start_capture(input logic [1:0] mode, input logic [15:0] post,
                                 input logic [7:0] value, input logic [7:0] mask);
        bus.trig_mode_i  = mode;
        bus.post_count_i = post;
        bus.trig_value_i = value;
        bus.trig_mask_i  = mask;
        bus.data_in      = 8'd0;
        free_run         = 1'b1;
        bus.arm_i        = 1'b1;
        tick();
        bus.arm_i = 1'b0;
    endtask

    task automatic run_to(input logic [7:0] target);
        int n = 0;
        while (bus.data_in != target && n < 300) begin
            tick();
            n++;
        end
        vectors++;
        if (bus.data_in !== target) begin
            miscompares++;
            $display("FAIL run_to data_in=%0d required=%0d", bus.data_in, target);
        end
    endtask

    task automatic pulse_ext();
        bus.ext_trigger_i = 1'b1;
        tick();
        bus.ext_trigger_i = 1'b0;
    endtask

    task automatic wait_done(input int exp_cycles, input string name);
        int n = 0;
        while (!bus.done_o && n < 64) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== exp_cycles) begin
            miscompares++;
            $display("FAIL %s done_latency got=%0d required=%0d", name, n, exp_cycles);
        end
    endtask

    task automatic read_counter_block(input logic [7:0] first, input string name);
        bus.rd_req_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            vectors++;
            if (bus.rd_valid_o !== 1'b1 || bus.data_out !== first + 8'(i) ||
                bus.rd_last_o !== (i == 15)) begin
                miscompares++;
                $display("FAIL %s word%0d got v=%b d=%0d l=%b required v=1 d=%0d l=%b",
                         name, i, bus.rd_valid_o, bus.data_out, bus.rd_last_o,
                         first + 8'(i), (i == 15));
            end
        end
        bus.rd_req_i = 1'b0;
        vectors++;
        if (bus.done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_after_last got=%b required=0", name, bus.done_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.arm_i = 1'b0; bus.ext_trigger_i = 1'b0; bus.trig_mode_i = 2'b00;
        bus.trig_value_i = 8'd0; bus.trig_mask_i = 8'd0; bus.post_count_i = 16'd0;
        bus.data_in = 8'd0; bus.rd_req_i = 1'b0; free_run = 1'b0;
        tick(); tick();
        vectors++;
        if ({bus.data_out, bus.rd_valid_o, bus.rd_last_o, bus.primed_o, bus.triggered_o,
             bus.done_o, bus.trig_addr_o} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got d=%0h v=%b l=%b p=%b t=%b dn=%b ta=%0d required all 0",
                     bus.data_out, bus.rd_valid_o, bus.rd_last_o, bus.primed_o,
                     bus.triggered_o, bus.done_o, bus.trig_addr_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ext_trigger();
        start_capture(2'b00, 16'd3, 8'd0, 8'd0);
        run_to(8'd40);
        pulse_ext();
        vectors++;
        if (bus.triggered_o !== 1'b1 || bus.trig_addr_o !== 4'd7) begin
            miscompares++;
            $display("FAIL ext_trig got t=%b ta=%0d required t=1 ta=7", bus.triggered_o, bus.trig_addr_o);
        end
        wait_done(3, "ext_post3");
        read_counter_block(8'd28, "ext_read");
        tick();
        vectors++;
        if (bus.rd_valid_o !== 1'b0 || bus.triggered_o !== 1'b1 || bus.primed_o !== 1'b1 ||
            bus.trig_addr_o !== 4'd7) begin
            miscompares++;
            $display("FAIL ext_hold got v=%b t=%b p=%b ta=%0d required v=0 t=1 p=1 ta=7",
                     bus.rd_valid_o, bus.triggered_o, bus.primed_o, bus.trig_addr_o);
        end
    endtask

    task automatic test_fill_ignore();
        start_capture(2'b00, 16'd12, 8'd0, 8'd0);
        run_to(8'd5);
        pulse_ext();
        vectors++;
        if (bus.triggered_o !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_trig_ignored got t=%b required 0", bus.triggered_o);
        end
        run_to(8'd16);
        vectors++;
        if (bus.primed_o !== 1'b0) begin
            miscompares++;
            $display("FAIL primed_early got=%b required 0", bus.primed_o);
        end
        tick();
        vectors++;
        if (bus.primed_o !== 1'b1) begin
            miscompares++;
            $display("FAIL primed_16 got=%b required 1", bus.primed_o);
        end
        run_to(8'd20);
        pulse_ext();
        wait_done(12, "fill_post12");
        read_counter_block(8'd17, "fill_read");
    endtask

    task automatic test_pattern();
        int n = 0;
        start_capture(2'b01, 16'd0, 8'h3C, 8'hF0);
        while (!bus.triggered_o && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (bus.data_in !== 8'h31 || bus.done_o !== 1'b1 || bus.trig_addr_o !== 4'd15) begin
            miscompares++;
            $display("FAIL pattern_trig got next=%0h dn=%b ta=%0d required next=31 dn=1 ta=15",
                     bus.data_in, bus.done_o, bus.trig_addr_o);
        end
        read_counter_block(8'h21, "pattern_read");
    endtask

    task automatic test_rising_edge();
        logic [7:0] exp;
        bus.trig_mode_i = 2'b11; bus.trig_value_i = 8'h55; bus.trig_mask_i = 8'hFF;
        bus.post_count_i = 16'd2; free_run = 1'b0; bus.data_in = 8'h55;
        bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        vectors++;
        if (bus.primed_o !== 1'b1 || bus.triggered_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rise_held got p=%b t=%b required p=1 t=0", bus.primed_o, bus.triggered_o);
        end
        bus.data_in = 8'h00;
        tick();
        bus.data_in = 8'h55;
        tick();
        vectors++;
        if (bus.triggered_o !== 1'b1 || bus.trig_addr_o !== 4'd6) begin
            miscompares++;
            $display("FAIL rise_trig got t=%b ta=%0d required t=1 ta=6", bus.triggered_o, bus.trig_addr_o);
        end
        tick();
        vectors++;
        if (bus.done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rise_done_early got=%b required 0", bus.done_o);
        end
        tick();
        vectors++;
        if (bus.done_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rise_done got=%b required 1", bus.done_o);
        end
        bus.rd_req_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp = (i == 12) ? 8'h00 : 8'h55;
            vectors++;
            if (bus.rd_valid_o !== 1'b1 || bus.data_out !== exp) begin
                miscompares++;
                $display("FAIL rise_read word%0d got v=%b d=%0h required v=1 d=%0h",
                         i, bus.rd_valid_o, bus.data_out, exp);
            end
        end
        bus.rd_req_i = 1'b0;
    endtask

    task automatic test_clamp();
        start_capture(2'b00, 16'd20, 8'd0, 8'd0);
        run_to(8'd40);
        pulse_ext();
        wait_done(15, "clamp_post");
        read_counter_block(8'd40, "clamp_read");
    endtask

    task automatic test_reset_mid_post();
        start_capture(2'b00, 16'd10, 8'd0, 8'd0);
        run_to(8'd40);
        pulse_ext();
        tick(); tick();
        vectors++;
        if (bus.triggered_o !== 1'b1 || bus.done_o !== 1'b0 || bus.data_out === 8'd0) begin
            miscompares++;
            $display("FAIL mid_post_state got t=%b dn=%b d=%0h required t=1 dn=0 d!=0",
                     bus.triggered_o, bus.done_o, bus.data_out);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.data_out, bus.rd_valid_o, bus.rd_last_o, bus.primed_o, bus.triggered_o,
             bus.done_o, bus.trig_addr_o} !== 17'd0) begin
            miscompares++;
            $display("FAIL async_reset got d=%0h p=%b t=%b dn=%b ta=%0d required all 0",
                     bus.data_out, bus.primed_o, bus.triggered_o, bus.done_o, bus.trig_addr_o);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        vectors++;
        if (bus.done_o !== 1'b0 || bus.primed_o !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle got dn=%b p=%b required 0 0", bus.done_o, bus.primed_o);
        end
    endtask

    task automatic test_abort_readout();
        start_capture(2'b00, 16'd3, 8'd0, 8'd0);
        run_to(8'd40);
        pulse_ext();
        wait_done(3, "abort_post3");
        bus.rd_req_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (bus.rd_valid_o !== 1'b1 || bus.data_out !== 8'd28 + 8'(i)) begin
                miscompares++;
                $display("FAIL abort_read word%0d got v=%b d=%0d required v=1 d=%0d",
                         i, bus.rd_valid_o, bus.data_out, 8'd28 + 8'(i));
            end
        end
        bus.arm_i = 1'b1;
        tick();
        bus.arm_i = 1'b0;
        vectors++;
        if (bus.rd_valid_o !== 1'b0 || bus.done_o !== 1'b0 || bus.primed_o !== 1'b0 ||
            bus.triggered_o !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_arm got v=%b dn=%b p=%b t=%b required all 0",
                     bus.rd_valid_o, bus.done_o, bus.primed_o, bus.triggered_o);
        end
        for (int i = 0; i < 15; i++) tick();
        vectors++;
        if (bus.primed_o !== 1'b0 || bus.rd_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_refill15 got p=%b v=%b required 0 0", bus.primed_o, bus.rd_valid_o);
        end
        tick();
        vectors++;
        if (bus.primed_o !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_refill16 got p=%b required 1", bus.primed_o);
        end
        bus.rd_req_i = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_ext_trigger();
        test_fill_ignore();
        test_pattern();
        test_rising_edge();
        test_clamp();
        test_reset_mid_post();
        test_abort_readout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
